w_sram_to_wtile_burst: RTL and testbench

W_SRAM_TO_WTILE_BURST -- requirements
Module: w_sram_to_Wtile_burst

---
 rtl/w_sram_to_wtile_burst.sv | 211 +++++++++++++++++++++
 tb/tb_w_sram_to_wtile_burst.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_sram_to_wtile_burst.sv
// Bursts columns of an M x KMAX weight tile out of SRAM into a flat tile register.
// Optional WTILE_CLEAR_ON_START_EN: zero the whole tile on every accepted start.
module w_sram_to_wtile_burst #(
    parameter int M        = 8,
    parameter int KMAX     = 1024,
    parameter int DATA_W   = 32,
    parameter int BYTE_W   = DATA_W / 8,
    parameter int ROW_W    = (M > 1) ? $clog2(M) : 1,
    parameter int K_W      = (KMAX > 1) ? $clog2(KMAX) : 1,
    parameter int NCOL_MAX = 16,
    parameter int NC_W     = $clog2(NCOL_MAX + 1),
    parameter int MAX_OUT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [K_W-1:0]           k_base,
    input  logic [NC_W-1:0]          ncol,
    output logic                     busy,
    output logic                     blk_valid,
    input  logic                     blk_accept,
    output logic                     err_range,
    output logic                     err_orphan,
    output logic                     w_en,
    output logic                     w_re,
    output logic                     w_we,
    output logic [ROW_W-1:0]         w_row,
    output logic [K_W-1:0]           w_k,
    output logic [DATA_W-1:0]        w_wdata,
    output logic [BYTE_W-1:0]        w_wmask,
    input  logic [DATA_W-1:0]        w_rdata,
    input  logic                     w_rvalid,
    output logic [M*KMAX*DATA_W-1:0] W_tile_flat
);

    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam int PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int TAG_W  = ROW_W + K_W;
    localparam int SUM_W  = ((K_W > NC_W) ? K_W : NC_W) + 1;
    localparam int TILE_W = M * KMAX * DATA_W;
    localparam int OFF_W  = $clog2(TILE_W);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [K_W-1:0]    last_k_q, last_k_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              err_range_q, err_range_d;
    logic              err_orphan_q, err_orphan_d;
    logic [TILE_W-1:0] tile_q;
    logic [TAG_W-1:0]  tag_mem [MAX_OUT];

    logic [SUM_W-1:0]  sum_w;
    logic              range_ok, start_ok, start_bad;
    logic              issue, last_issue, pop, orphan;
    logic [TAG_W-1:0]  pop_tag;
    logic [ROW_W-1:0]  pop_row;
    logic [K_W-1:0]    pop_k;
    logic [OFF_W-1:0]  pop_off;

    // Widened sum so k_base+ncol cannot wrap before the bound check
    assign sum_w     = SUM_W'(k_base) + SUM_W'(ncol);
    assign range_ok  = (ncol <= NC_W'(NCOL_MAX)) && (sum_w <= SUM_W'(KMAX));
    assign start_ok  = (state_q == S_IDLE) && start && range_ok;
    assign start_bad = (state_q == S_IDLE) && start && !range_ok;

    assign issue      = (state_q == S_ISSUE) && (cnt_q < CNT_W'(MAX_OUT));
    assign last_issue = issue && (row_q == ROW_W'(M - 1)) && (k_q == last_k_q);
    assign pop        = w_rvalid && (cnt_q != '0);
    assign orphan     = w_rvalid && (cnt_q == '0);

    assign pop_tag = tag_mem[rd_ptr_q];
    assign pop_row = pop_tag[TAG_W-1:K_W];
    assign pop_k   = pop_tag[K_W-1:0];
    assign pop_off = OFF_W'((int'(pop_row) * KMAX + int'(pop_k)) * DATA_W);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            k_q          <= '0;
            last_k_q     <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_range_q  <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            k_q          <= k_d;
            last_k_q     <= last_k_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_range_q  <= err_range_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (ncol == '0) ? S_HOLD : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (cnt_q == CNT_W'(1))) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (blk_accept) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address walk, outstanding count and tag FIFO pointers
    always_comb begin
        row_d        = row_q;
        k_d          = k_q;
        last_k_d     = last_k_q;
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        err_range_d  = start_bad;
        err_orphan_d = err_orphan_q | orphan;

        if (start_ok) begin
            row_d    = '0;
            k_d      = k_base;
            last_k_d = K_W'(sum_w - SUM_W'(1));
        end else if (issue) begin
            if (row_q == ROW_W'(M - 1)) begin
                row_d = '0;
                k_d   = k_q + K_W'(1);
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end

        if (issue && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!issue && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (issue) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    // Output logic
    always_comb begin
        busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        blk_valid = (state_q == S_HOLD);
        w_en      = issue;
        w_re      = issue;
        w_we      = 1'b0;
        w_row     = issue ? row_q : '0;
        w_k       = issue ? k_q : '0;
    end

    assign err_range   = err_range_q;
    assign err_orphan  = err_orphan_q;
    assign w_wdata     = '0;
    assign w_wmask     = '0;
    assign W_tile_flat = tile_q;

    // Tag FIFO storage; occupancy is tracked by cnt_q
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr_q] <= {row_q, k_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_q <= '0;
        end else begin
`ifdef WTILE_CLEAR_ON_START_EN
            if (start_ok) begin
                tile_q <= '0;
            end
`endif
            if (pop) begin
                tile_q[pop_off +: DATA_W] <= w_rdata;
            end
        end
    end

endmodule

// File: tb/tb_w_sram_to_wtile_burst.sv
// Directed bench for w_sram_to_wtile_burst with a variable-latency in-order SRAM model.
module tb_w_sram_to_wtile_burst;

    localparam int M      = 8;
    localparam int KMAX   = 1024;
    localparam int DATA_W = 32;
`ifdef WTILE_CLEAR_ON_START_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic                     start;
    logic [9:0]               k_base;
    logic [4:0]               ncol;
    logic                     busy;
    logic                     blk_valid;
    logic                     blk_accept;
    logic                     err_range;
    logic                     err_orphan;
    logic                     w_en;
    logic                     w_re;
    logic                     w_we;
    logic [2:0]               w_row;
    logic [9:0]               w_k;
    logic [31:0]              w_wdata;
    logic [3:0]               w_wmask;
    logic [31:0]              w_rdata;
    logic                     w_rvalid;
    logic [M*KMAX*DATA_W-1:0] W_tile_flat;

    w_sram_to_wtile_burst dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .k_base     (k_base),
        .ncol       (ncol),
        .busy       (busy),
        .blk_valid  (blk_valid),
        .blk_accept (blk_accept),
        .err_range  (err_range),
        .err_orphan (err_orphan),
        .w_en       (w_en),
        .w_re       (w_re),
        .w_we       (w_we),
        .w_row      (w_row),
        .w_k        (w_k),
        .w_wdata    (w_wdata),
        .w_wmask    (w_wmask),
        .w_rdata    (w_rdata),
        .w_rvalid   (w_rvalid),
        .W_tile_flat(W_tile_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int row;
        int k;
    } req_t;

    req_t q[$];
    int   cyc, lat;
    int   exp_row, exp_k;
    int   rd_count, rv_count, tb_out, max_out, order_err, we_err;
    bit   stray;
    int   pass_cnt, total_cnt;
    int   n;

    function automatic logic [31:0] tile(input int r, input int k);
        return W_tile_flat[18'((r * KMAX + k) * DATA_W) +: 32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        $display("check %-18s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: observe requests at the falling edge, drive the response for the next rising edge
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (w_en === 1'b1) begin
            rd_count++;
            tb_out++;
            if (w_we !== 1'b0 || w_re !== 1'b1) we_err++;
            if (int'(w_row) != exp_row || int'(w_k) != exp_k) order_err++;
            q.push_back('{due: cyc + lat, row: int'(w_row), k: int'(w_k)});
            exp_row++;
            if (exp_row == M) begin
                exp_row = 0;
                exp_k++;
            end
        end
        if (stray) begin
            w_rvalid = 1'b1;
            w_rdata  = 32'h5A5A_5A5A;
            stray    = 1'b0;
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            w_rvalid = 1'b1;
            w_rdata  = 32'hA000_0000 + 32'(q[0].row << 16) + 32'(q[0].k);
            void'(q.pop_front());
            rv_count++;
            tb_out--;
        end else begin
            w_rvalid = 1'b0;
            w_rdata  = '0;
        end
        if (tb_out > max_out) max_out = tb_out;
    endtask

    task automatic prep(input int kb, input int latency);
        lat       = latency;
        exp_row   = 0;
        exp_k     = kb;
        rd_count  = 0;
        rv_count  = 0;
        tb_out    = 0;
        max_out   = 0;
        order_err = 0;
        we_err    = 0;
    endtask

    // Returns the cycle index (start cycle = 0) at which blk_valid is first seen
    task automatic run_burst(input int kb, input int nc, input int latency, output int ncyc);
        prep(kb, latency);
        k_base = 10'(kb);
        ncol   = 5'(nc);
        start  = 1'b1;
        cycle();
        start = 1'b0;
        ncyc  = 1;
        while (blk_valid !== 1'b1 && ncyc < 3000) begin
            cycle();
            ncyc++;
        end
    endtask

    task automatic accept();
        blk_accept = 1'b1;
        cycle();
        blk_accept = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; k_base = '0; ncol = '0; blk_accept = 1'b0;
        w_rvalid = 1'b0; w_rdata = '0; stray = 1'b0;
        pass_cnt = 0; total_cnt = 0; cyc = 0;
        prep(0, 1);
        repeat (3) cycle();

        chk("rst_busy", 64'(busy), 0);
        chk("rst_blk_valid", 64'(blk_valid), 0);
        chk("rst_w_en", 64'(w_en), 0);
        chk("rst_err_orphan", 64'(err_orphan), 0);
        chk("rst_tile_zero", 64'(W_tile_flat == '0), 1);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Single column, 1-cycle SRAM
        run_burst(0, 1, 1, n);
        chk("A_valid_cycle", 64'(n), 10);
        chk("A_reads", 64'(rd_count), 8);
        chk("A_beats", 64'(rv_count), 8);
        chk("A_order", 64'(order_err), 0);
        chk("A_strobes", 64'(we_err), 0);
        chk("A_flat_7_0", 64'(tile(7, 0)), 64'h A007_0000);
        chk("A_flat_0_0", 64'(tile(0, 0)), 64'h A000_0000);
        chk("A_busy_hold", 64'(busy), 0);
        accept();
        chk("A_valid_drop", 64'(blk_valid), 0);
        chk("A_busy_idle", 64'(busy), 0);

        // Three columns, latency 3
        run_burst(9, 3, 3, n);
        chk("B_valid_cycle", 64'(n), 28);
        chk("B_maxout_le4", 64'(max_out <= 4), 1);
        chk("B_beats", 64'(rv_count), 24);
        chk("B_order", 64'(order_err), 0);
        chk("B_flat_5_11", 64'(tile(5, 11)), 64'h A005_000B);
        chk("B_flat_0_9", 64'(tile(0, 9)), 64'h A000_0009);
        chk("B_flat_7_0", 64'(tile(7, 0)), CLR ? 64'h0 : 64'h A007_0000);
        chk("B_flat_3_8", 64'(tile(3, 8)), 0);
        chk("B_flat_2_12", 64'(tile(2, 12)), 0);
        accept();

        // Long latency forces the in-flight limit
        run_burst(20, 2, 8, n);
        chk("C_done", 64'(blk_valid), 1);
        chk("C_maxout", 64'(max_out), 4);
        chk("C_beats", 64'(rv_count), 16);
        chk("C_order", 64'(order_err), 0);
        chk("C_flat_6_21", 64'(tile(6, 21)), 64'h A006_0015);
        accept();

        // Accept during ISSUE and start during HOLD are ignored
        prep(0, 1);
        k_base = 10'd0; ncol = 5'd1; start = 1'b1;
        cycle();
        start = 1'b0; blk_accept = 1'b1;
        cycle();
        blk_accept = 1'b0;
        chk("D_busy_after_acc", 64'(busy), 1);
        n = 0;
        while (blk_valid !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        chk("D_hold", 64'(blk_valid), 1);
        chk("D_reads", 64'(rd_count), 8);
        rd_count = 0;
        k_base = 10'd50; ncol = 5'd2; start = 1'b1;
        cycle();
        start = 1'b0;
        chk("D_start_in_hold", 64'(blk_valid), 1);
        chk("D_no_busy_hold", 64'(busy), 0);
        accept();
        chk("D_valid_drop", 64'(blk_valid), 0);
        repeat (3) cycle();
        chk("D_no_reads", 64'(rd_count), 0);
        chk("D_flat_5_9", 64'(tile(5, 9)), CLR ? 64'h0 : 64'h A005_0009);
        chk("D_flat_7_0", 64'(tile(7, 0)), 64'h A007_0000);

        // Range rejections, then an empty burst
        prep(1020, 1);
        k_base = 10'd1020; ncol = 5'd5; start = 1'b1;
        cycle();
        start = 1'b0;
        chk("E_err_pulse", 64'(err_range), 1);
        chk("E_not_busy", 64'(busy), 0);
        cycle();
        chk("E_err_clear", 64'(err_range), 0);
        k_base = 10'd0; ncol = 5'd17; start = 1'b1;
        cycle();
        start = 1'b0;
        chk("E_err_ncol17", 64'(err_range), 1);
        repeat (2) cycle();
        chk("E_no_reads", 64'(rd_count), 0);
        run_burst(1020, 0, 1, n);
        chk("E_empty_cycle", 64'(n), 1);
        chk("E_empty_reads", 64'(rd_count), 0);
        accept();

        // Both bounds at their limits
        run_burst(1008, 16, 2, n);
        chk("F_valid_cycle", 64'(n), 131);
        chk("F_flat_7_1023", 64'(tile(7, 1023)), 64'h A007_03FF);
        chk("F_flat_0_1008", 64'(tile(0, 1008)), 64'h A000_03F0);
        chk("F_order", 64'(order_err), 0);
        accept();

        // Stray response while idle
        prep(0, 1);
        stray = 1'b1;
        cycle();
        cycle();
        chk("G_orphan", 64'(err_orphan), 1);
        chk("G_not_busy", 64'(busy), 0);
        chk("G_flat_4_1023", 64'(tile(4, 1023)), 64'h A004_03FF);
        chk("G_flat_7_1023", 64'(tile(7, 1023)), 64'h A007_03FF);
        run_burst(40, 1, 1, n);
        chk("G_next_cycle", 64'(n), 10);
        chk("G_flat_3_40", 64'(tile(3, 40)), 64'h A003_0028);
        accept();

        // Reset in the middle of a burst
        prep(30, 6);
        k_base = 10'd30; ncol = 5'd2; start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (rv_count < 3 && n < 100) begin
            cycle();
            n++;
        end
        chk("H_reached_beat3", 64'(rv_count), 3);
        rst_n = 1'b0;
        #1;
        chk("H_busy", 64'(busy), 0);
        chk("H_blk_valid", 64'(blk_valid), 0);
        chk("H_err_range", 64'(err_range), 0);
        chk("H_err_orphan", 64'(err_orphan), 0);
        chk("H_strobes", 64'({w_en, w_re, w_we}), 0);
        chk("H_addr", 64'({w_row, w_k}), 0);
        chk("H_tile_zero", 64'(W_tile_flat == '0), 1);
        cycle();
        rst_n = 1'b1;
        repeat (10) cycle();
        chk("H_orphan_after", 64'(err_orphan), 1);
        chk("H_idle_after", 64'({busy, blk_valid}), 0);
        chk("H_tile_still_zero", 64'(W_tile_flat == '0), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
